// File: rtl/cpu_run_controller_if.sv
// Run-controller bus: start request, core observation inputs, run status and trace outputs.
interface cpu_run_controller_if #(
  parameter int unsigned STEP_W = 16,
  parameter int unsigned CYC_W  = 32
);

  logic              start;
  logic              fetch_state;
  logic              instr_valid;
  logic [31:0]       pc;
  logic [31:0]       instr;

  logic              cpu_rst;
  logic              running;
  logic              finish;
  logic [1:0]        result;
  logic [STEP_W-1:0] step_count;
  logic [CYC_W-1:0]  cycle_count;
  logic              trace_valid;
  logic [31:0]       trace_pc;
  logic [31:0]       trace_instr;

  // Controller side
  modport master (
    input  start, fetch_state, instr_valid, pc, instr,
    output cpu_rst, running, finish, result, step_count, cycle_count,
           trace_valid, trace_pc, trace_instr
  );

  // Core / bench side
  modport slave (
    output start, fetch_state, instr_valid, pc, instr,
    input  cpu_rst, running, finish, result, step_count, cycle_count,
           trace_valid, trace_pc, trace_instr
  );

endinterface

// File: rtl/cpu_run_controller.sv
// Run/supervision controller for the multi-cycle core: sequences core reset,
// counts retired instructions at fetch-state entry, emits a trace strobe per
// step and ends the run on halt, step limit or per-instruction timeout.
module cpu_run_controller #(
  parameter int unsigned RESET_CYCLES   = 2,
  parameter int unsigned MAX_STEPS      = 100,
  parameter int unsigned STEP_W         = 16,
  parameter int unsigned TIMEOUT_CYCLES = 10,
  parameter int unsigned CYC_W          = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  cpu_run_controller_if.master bus
);

  localparam int unsigned RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);

  localparam logic [1:0] RES_NONE    = 2'd0;
  localparam logic [1:0] RES_HALT    = 2'd1;
  localparam logic [1:0] RES_STEPS   = 2'd2;
  localparam logic [1:0] RES_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;

  logic              start_q;
  logic              fetch_q, fetch_d;
  logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic [TO_W-1:0]   idle_q, idle_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [1:0]        result_q, result_d;
  logic              trace_valid_q, trace_valid_d;
  logic [31:0]       trace_pc_q, trace_pc_d;
  logic [31:0]       trace_instr_q, trace_instr_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              running_q, running_d;
  logic              finish_q, finish_d;

  logic              start_rise;
  logic              boundary;
  logic              at_max;
  logic              idle_expired;
  logic              reset_done;

  // Event decode shared by the next-state and output logic
  assign start_rise   = bus.start & ~start_q;
  assign boundary     = (state_q == S_RUN) & bus.fetch_state & ~fetch_q;
  assign at_max       = (step_q == STEP_W'(MAX_STEPS));
  assign idle_expired = (idle_q == TO_W'(TIMEOUT_CYCLES - 1));
  assign reset_done   = (rst_cnt_q == RC_W'(RESET_CYCLES - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a boundary in the same cycle as idle expiry wins
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_rise) begin
          state_d = S_RESET;
        end
      end
      S_RESET: begin
        if (reset_done) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (boundary) begin
          if (at_max || !bus.instr_valid) begin
            state_d = S_DONE;
          end
        end else if (idle_expired) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (start_rise) begin
          state_d = S_RESET;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values; everything holds unless a state acts on it
  always_comb begin
    fetch_d       = 1'b0;
    rst_cnt_d     = rst_cnt_q;
    idle_d        = idle_q;
    step_d        = step_q;
    cyc_d         = cyc_q;
    result_d      = result_q;
    trace_valid_d = 1'b0;
    trace_pc_d    = trace_pc_q;
    trace_instr_d = trace_instr_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_rise) begin
          rst_cnt_d = '0;
          idle_d    = '0;
          step_d    = '0;
          cyc_d     = '0;
          result_d  = RES_NONE;
        end
      end
      S_RESET: begin
        idle_d = '0;
        if (!reset_done) begin
          rst_cnt_d = rst_cnt_q + RC_W'(1);
        end
      end
      S_RUN: begin
        fetch_d = bus.fetch_state;
        if (~&cyc_q) begin
          cyc_d = cyc_q + CYC_W'(1);
        end
        if (boundary) begin
          if (at_max) begin
            result_d = RES_STEPS;
          end else if (!bus.instr_valid) begin
            result_d = RES_HALT;
          end else begin
            trace_valid_d = 1'b1;
            trace_pc_d    = bus.pc;
            trace_instr_d = bus.instr;
            step_d        = step_q + STEP_W'(1);
            idle_d        = '0;
          end
        end else if (idle_expired) begin
          result_d = RES_TIMEOUT;
        end else begin
          idle_d = idle_q + TO_W'(1);
        end
      end
      default: ;
    endcase

    cpu_rst_d = (state_d != S_RUN);
    running_d = (state_d == S_RUN);
    finish_d  = (state_d == S_DONE);
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      start_q       <= 1'b0;
      fetch_q       <= 1'b0;
      rst_cnt_q     <= '0;
      idle_q        <= '0;
      step_q        <= '0;
      cyc_q         <= '0;
      result_q      <= RES_NONE;
      trace_valid_q <= 1'b0;
      trace_pc_q    <= '0;
      trace_instr_q <= '0;
      cpu_rst_q     <= 1'b1;
      running_q     <= 1'b0;
      finish_q      <= 1'b0;
    end else begin
      start_q       <= bus.start;
      fetch_q       <= fetch_d;
      rst_cnt_q     <= rst_cnt_d;
      idle_q        <= idle_d;
      step_q        <= step_d;
      cyc_q         <= cyc_d;
      result_q      <= result_d;
      trace_valid_q <= trace_valid_d;
      trace_pc_q    <= trace_pc_d;
      trace_instr_q <= trace_instr_d;
      cpu_rst_q     <= cpu_rst_d;
      running_q     <= running_d;
      finish_q      <= finish_d;
    end
  end

  assign bus.cpu_rst     = cpu_rst_q;
  assign bus.running     = running_q;
  assign bus.finish      = finish_q;
  assign bus.result      = result_q;
  assign bus.step_count  = step_q;
  assign bus.cycle_count = cyc_q;
  assign bus.trace_valid = trace_valid_q;
  assign bus.trace_pc    = trace_pc_q;
  assign bus.trace_instr = trace_instr_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Bench for cpu_run_controller: programs of (gap, valid, pc, instr) steps are
// turned into expected traces/finish by a step-level model, then driven
// cycle by cycle while a monitor pops and compares on DUT events.
module tb_cpu_run_controller;

  localparam int unsigned RESET_CYCLES   = 2;
  localparam int unsigned MAX_STEPS      = 5;
  localparam int unsigned STEP_W         = 16;
  localparam int unsigned TIMEOUT_CYCLES = 10;
  localparam int unsigned CYC_W          = 32;

  localparam int TO   = TIMEOUT_CYCLES;
  localparam int MAXS = MAX_STEPS;

  typedef struct {
    int          at;
    logic [31:0] pc;
    logic [31:0] instr;
    int          step;
  } trace_exp_t;

  typedef struct {
    int at;
    int res;
    int steps;
    int cycles;
  } fin_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  cpu_run_controller_if #(.STEP_W(STEP_W), .CYC_W(CYC_W)) bus ();

  cpu_run_controller #(
    .RESET_CYCLES  (RESET_CYCLES),
    .MAX_STEPS     (MAX_STEPS),
    .STEP_W        (STEP_W),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CYC_W         (CYC_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  trace_exp_t tq[$];
  fin_exp_t   fq[$];
  int         rq[$];

  int checks     = 0;
  int failures   = 0;
  int fin_events = 0;
  int last_res   = 0;

  int          pn;
  int          pgap[16];
  bit          pval[16];
  logic [31:0] ppc[16];
  logic [31:0] pins[16];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void fail_evt(input string name);
    checks++;
    failures++;
    $display("FAIL %s: unexpected DUT event (cycle %0d)", name, cyc);
  endfunction

  task automatic check_reset_values(input string tag);
    chk({tag, "_cpu_rst"},     bus.cpu_rst, 1);
    chk({tag, "_running"},     bus.running, 0);
    chk({tag, "_finish"},      bus.finish, 0);
    chk({tag, "_result"},      bus.result, 0);
    chk({tag, "_step_count"},  bus.step_count, 0);
    chk({tag, "_cycle_count"}, bus.cycle_count, 0);
    chk({tag, "_trace_valid"}, bus.trace_valid, 0);
    chk({tag, "_trace_pc"},    bus.trace_pc, 0);
    chk({tag, "_trace_instr"}, bus.trace_instr, 0);
  endtask

  // Step-level reference: RUN cycle 0 is t=0, a virtual boundary sits at t=-1,
  // and each step must arrive within TO cycles of the previous one.
  task automatic model_run(input int run0, output int t_end);
    int prev, steps, res, t;
    bit stopped;
    trace_exp_t te;
    fin_exp_t fe;
    prev = -1; steps = 0; res = 3; stopped = 0; t_end = 0;
    for (int i = 0; i < pn && !stopped; i++) begin
      if (pgap[i] > TO) begin
        t_end = prev + TO; res = 3; stopped = 1;
      end else begin
        t = prev + pgap[i];
        if (steps == MAXS) begin
          t_end = t; res = 2; stopped = 1;
        end else if (!pval[i]) begin
          t_end = t; res = 1; stopped = 1;
        end else begin
          te.at = run0 + t + 1; te.pc = ppc[i]; te.instr = pins[i]; te.step = steps + 1;
          tq.push_back(te);
          steps++;
          prev = t;
        end
      end
    end
    if (!stopped) t_end = prev + TO;
    fe.at = run0 + t_end + 1; fe.res = res; fe.steps = steps; fe.cycles = t_end + 1;
    fq.push_back(fe);
    last_res = res;
  endtask

  task automatic junk_inputs();
    bus.fetch_state = 1'($urandom_range(0, 1));
    bus.instr_valid = 1'($urandom_range(0, 1));
    bus.pc          = $urandom;
    bus.instr       = $urandom;
  endtask

  // Drive one run of the current program; abort_at >= 0 asserts rst in that RUN cycle
  task automatic run_program(input bit repulse, input int abort_at);
    int m, run0, t_end, rp_at, hit, prev, k, fin_before;
    int bt[16];
    @(negedge clk); bus.start = 1'b0; junk_inputs();
    @(negedge clk); bus.start = 1'b1; junk_inputs();
    m = cyc;
    run0 = m + RESET_CYCLES + 1;
    fin_before = fin_events;
    rq.push_back(run0);
    model_run(run0, t_end);
    prev = -1;
    for (int i = 0; i < pn; i++) begin
      bt[i] = prev + pgap[i];
      prev = bt[i];
    end
    rp_at = (repulse && t_end >= 2) ? t_end / 2 : -10;
    repeat (RESET_CYCLES) begin
      @(negedge clk); junk_inputs();
    end
    for (int t = 0; t <= t_end; t++) begin
      @(negedge clk);
      if (t == abort_at) begin
        tq.delete(); fq.delete(); rq.delete();
        rst = 1'b1; bus.start = 1'b0;
        break;
      end
      hit = -1;
      for (int i = 0; i < pn; i++) if (bt[i] == t) hit = i;
      if (hit >= 0) begin
        bus.fetch_state = 1'b1;
        bus.instr_valid = pval[hit];
        bus.pc          = ppc[hit];
        bus.instr       = pins[hit];
      end else begin
        junk_inputs();
        bus.fetch_state = 1'b0;
      end
      if (t == rp_at) bus.start = 1'b0;
      if (t == rp_at + 1) bus.start = 1'b1;
    end
    if (abort_at >= 0) begin
      @(negedge clk);
      check_reset_values("midrun_rst");
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("after_rst_stays_idle", bus.running, 0);
    end else begin
      @(negedge clk); bus.fetch_state = 1'b0;
      k = 0;
      while (fin_events == fin_before && k < 40) begin
        @(negedge clk); k++;
      end
      chk("finish_seen", fin_events > fin_before, 1);
      repeat ($urandom_range(1, 4)) @(negedge clk);
      chk("done_finish_hold", bus.finish, 1);
      chk("done_result_hold", bus.result, 64'(last_res));
      chk("done_cpu_rst",     bus.cpu_rst, 1);
    end
  endtask

  task automatic set_regular(input int n, input int gap);
    pn = n;
    for (int i = 0; i < n; i++) begin
      pgap[i] = gap;
      pval[i] = 1'b1;
      ppc[i]  = 32'h0040_0000 + 32'(i * 4);
      pins[i] = $urandom;
    end
  endtask

  task automatic set_random();
    int r;
    pn = $urandom_range(1, MAXS + 2);
    for (int i = 0; i < pn; i++) begin
      r = $urandom_range(0, 19);
      if (i == 0) pgap[i] = (r == 0) ? $urandom_range(TO + 1, TO + 3) : $urandom_range(1, TO);
      else        pgap[i] = (r == 0) ? $urandom_range(TO + 1, TO + 3) :
                            (r < 4) ? TO : $urandom_range(2, TO);
      pval[i] = ($urandom_range(0, 11) != 0);
      ppc[i]  = $urandom;
      pins[i] = $urandom;
    end
  endtask

  // Monitor: compares DUT events against the scoreboard queues
  initial begin
    bit run_prev, fin_prev;
    trace_exp_t te;
    fin_exp_t fe;
    int r0;
    run_prev = 1'b0;
    fin_prev = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus.trace_valid === 1'b1) begin
        if (tq.size() == 0) fail_evt("trace_unexpected");
        else begin
          te = tq.pop_front();
          chk("trace_cycle", cyc, te.at);
          chk("trace_pc",    bus.trace_pc, te.pc);
          chk("trace_instr", bus.trace_instr, te.instr);
          chk("trace_step",  bus.step_count, te.step);
        end
      end
      if (bus.running === 1'b1 && !run_prev) begin
        if (rq.size() == 0) fail_evt("running_unexpected");
        else begin
          r0 = rq.pop_front();
          chk("run_start_cycle", cyc, r0);
          chk("run_start_steps", bus.step_count, 0);
          chk("run_start_cycles", bus.cycle_count, 0);
          chk("run_start_result", bus.result, 0);
          chk("run_start_finish", bus.finish, 0);
          chk("run_start_cpu_rst", bus.cpu_rst, 0);
        end
      end
      if (bus.finish === 1'b1 && !fin_prev) begin
        fin_events++;
        if (fq.size() == 0) fail_evt("finish_unexpected");
        else begin
          fe = fq.pop_front();
          chk("finish_cycle",  cyc, fe.at);
          chk("finish_result", bus.result, 64'(fe.res));
          chk("finish_steps",  bus.step_count, fe.steps);
          chk("finish_cycles", bus.cycle_count, fe.cycles);
          chk("finish_running", bus.running, 0);
          chk("finish_cpu_rst", bus.cpu_rst, 1);
        end
      end
      run_prev = (bus.running === 1'b1);
      fin_prev = (bus.finish === 1'b1);
    end
  end

  // Stimulus
  initial begin
    bus.start = 1'b0;
    bus.fetch_state = 1'b0;
    bus.instr_valid = 1'b1;
    bus.pc = '0;
    bus.instr = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_no_start", bus.running, 0);

    // Steady fetch every 4 cycles until the step limit stops the run
    set_regular(MAXS + 1, 4);
    run_program(1'b0, -1);

    // Undefined instruction at the third boundary
    set_regular(4, 4);
    pval[2] = 1'b0;
    run_program(1'b0, -1);

    // One step, then fetch stuck low
    set_regular(1, 4);
    run_program(1'b0, -1);

    // Boundaries exactly at the timeout limit, plus start re-pulse during RUN
    set_regular(3, TO);
    run_program(1'b1, -1);

    // Reset asserted in the middle of a run
    set_regular(6, 4);
    run_program(1'b0, 9);

    for (int r = 0; r < 40; r++) begin
      set_random();
      run_program(1'($urandom_range(0, 1)), -1);
    end

    repeat (3) @(negedge clk);
    chk("trace_queue_drained",  tq.size(), 0);
    chk("finish_queue_drained", fq.size(), 0);
    chk("run_queue_drained",    rq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
